// File: rtl/pipeline_pkg.sv
// Shared IF/ID pipeline definitions: NOP encoding, entry payload type and
// the instruction field slice positions used by decode.
package pipeline_pkg;

  localparam int unsigned DEF_PC_W    = 32;
  localparam int unsigned DEF_INSTR_W = 32;
  localparam int unsigned SLICE_W     = 32;

  localparam logic [DEF_INSTR_W-1:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [DEF_PC_W-1:0]    pc;
    logic [DEF_INSTR_W-1:0] instr;
  } if_id_entry_t;

  // Field slice bounds within a 32-bit instruction word
  localparam int unsigned SL_A_HI = 31;
  localparam int unsigned SL_A_LO = 30;
  localparam int unsigned SL_B_HI = 29;
  localparam int unsigned SL_B_LO = 25;
  localparam int unsigned SL_C_HI = 27;
  localparam int unsigned SL_C_LO = 24;
  localparam int unsigned SL_D_HI = 27;
  localparam int unsigned SL_D_LO = 0;

endpackage

// File: rtl/pipe_entry_reg.sv
// One pipeline entry: valid bit plus PC/instruction payload with load and clear.
// A cleared or reset entry holds pc=0 and the NOP encoding.
module pipe_entry_reg
  import pipeline_pkg::*;
#(
  parameter int unsigned          PC_W      = 32,
  parameter int unsigned          INSTR_W   = 32,
  parameter logic [INSTR_W-1:0]   NOP_INSTR = INSTR_W'(NOP_INSTR_DEFAULT)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               clear,
  input  logic [PC_W-1:0]    d_pc,
  input  logic [INSTR_W-1:0] d_instr,
  output logic               valid,
  output logic [PC_W-1:0]    pc,
  output logic [INSTR_W-1:0] instr
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      valid <= 1'b0;
      pc    <= '0;
      instr <= NOP_INSTR;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= d_pc;
      instr <= d_instr;
    end
  end

endmodule

// File: rtl/segment_if_id_elastic.sv
// Elastic IF/ID segment: valid/ready handshake, optional 2-entry skid buffer,
// flush with NOP bubble, decode field slices and a saturating stall counter.
module segment_if_id_elastic
  import pipeline_pkg::*;
#(
  parameter int unsigned        PC_W      = 32,
  parameter int unsigned        INSTR_W   = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEFAULT),
  parameter bit                 SKID_EN   = 1'b1,
  parameter int unsigned        CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               if_valid,
  output logic               if_ready,
  input  logic [PC_W-1:0]    pc_out,
  input  logic [INSTR_W-1:0] instruction,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [PC_W-1:0]    pc,
  output logic [INSTR_W-1:0] instr,
  output logic [1:0]         instr_31_30,
  output logic [4:0]         instr_29_25,
  output logic [3:0]         instr_27_24,
  output logic [27:0]        instr_27_0,
  output logic [CNT_W-1:0]   stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic               m_valid, s_valid;
  logic [PC_W-1:0]    m_pc, s_pc, m_d_pc;
  logic [INSTR_W-1:0] m_instr, s_instr, m_d_instr;
  logic               m_load, m_clear, s_load, s_clear, m_sel_s;
  logic               accept_c, pop_c;
  logic [SLICE_W-1:0] instr_view;

  // With the skid buffer, ready depends only on the S flop, never on id_ready
  assign if_ready = SKID_EN ? !s_valid : (!m_valid || id_ready);
  assign accept_c = if_valid && if_ready;
  assign pop_c    = m_valid && id_ready;

  always_comb begin
    m_load  = 1'b0;
    m_clear = 1'b0;
    s_load  = 1'b0;
    s_clear = 1'b0;
    m_sel_s = 1'b0;
    if (flush) begin
      m_clear = 1'b1;
      s_clear = 1'b1;
    end else if (SKID_EN) begin
      if (pop_c) begin
        if (s_valid) begin
          m_load  = 1'b1;
          m_sel_s = 1'b1;
          if (accept_c) s_load  = 1'b1;
          else          s_clear = 1'b1;
        end else if (accept_c) begin
          m_load = 1'b1;
        end else begin
          m_clear = 1'b1;
        end
      end else if (accept_c) begin
        if (m_valid) s_load = 1'b1;
        else         m_load = 1'b1;
      end
    end else begin
      if (accept_c)   m_load  = 1'b1;
      else if (pop_c) m_clear = 1'b1;
    end
  end

  assign m_d_pc    = m_sel_s ? s_pc    : pc_out;
  assign m_d_instr = m_sel_s ? s_instr : instruction;

  pipe_entry_reg #(
    .PC_W      (PC_W),
    .INSTR_W   (INSTR_W),
    .NOP_INSTR (NOP_INSTR)
  ) u_m (
    .clk     (clk),
    .rst     (rst),
    .load    (m_load),
    .clear   (m_clear),
    .d_pc    (m_d_pc),
    .d_instr (m_d_instr),
    .valid   (m_valid),
    .pc      (m_pc),
    .instr   (m_instr)
  );

  pipe_entry_reg #(
    .PC_W      (PC_W),
    .INSTR_W   (INSTR_W),
    .NOP_INSTR (NOP_INSTR)
  ) u_s (
    .clk     (clk),
    .rst     (rst),
    .load    (s_load),
    .clear   (s_clear),
    .d_pc    (pc_out),
    .d_instr (instruction),
    .valid   (s_valid),
    .pc      (s_pc),
    .instr   (s_instr)
  );

  assign id_valid = m_valid;
  assign pc       = m_pc;
  assign instr    = m_instr;

  // Decode slices straight off the head register, no added latency
  assign instr_view  = SLICE_W'(m_instr);
  assign instr_31_30 = instr_view[SL_A_HI:SL_A_LO];
  assign instr_29_25 = instr_view[SL_B_HI:SL_B_LO];
  assign instr_27_24 = instr_view[SL_C_HI:SL_C_LO];
  assign instr_27_0  = instr_view[SL_D_HI:SL_D_LO];

  // Saturating count of cycles the head is held by decode; flush leaves it alone
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (m_valid && !id_ready && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_segment_if_id_elastic.sv
// Bench for segment_if_id_elastic: skid and non-skid instances driven in parallel,
// checked each cycle against queue-based models plus directed literal expectations.
module tb_segment_if_id_elastic;
  import pipeline_pkg::*;

  localparam int CW      = 4;
  localparam int CNT_SAT = 15;

  logic        clk = 1'b0;
  logic        rst, flush, if_valid, id_ready;
  logic [31:0] pc_out, instruction;

  logic        if_ready1, id_valid1, if_ready0, id_valid0;
  logic [31:0] pc1, instr1, pc0, instr0;
  logic [1:0]  a1, a0;
  logic [4:0]  b1, b0;
  logic [3:0]  c1, c0;
  logic [27:0] d1, d0;
  logic [CW-1:0] sc1, sc0;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  if_id_entry_t q1[$];
  if_id_entry_t q0[$];
  int cnt1 = 0;
  int cnt0 = 0;

  always #5 clk = ~clk;

  segment_if_id_elastic #(.SKID_EN(1'b1), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .if_valid(if_valid), .if_ready(if_ready1),
    .pc_out(pc_out), .instruction(instruction), .id_valid(id_valid1), .id_ready(id_ready),
    .pc(pc1), .instr(instr1), .instr_31_30(a1), .instr_29_25(b1), .instr_27_24(c1),
    .instr_27_0(d1), .stall_cnt(sc1)
  );

  segment_if_id_elastic #(.SKID_EN(1'b0), .CNT_W(CW)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .if_valid(if_valid), .if_ready(if_ready0),
    .pc_out(pc_out), .instruction(instruction), .id_valid(id_valid0), .id_ready(id_ready),
    .pc(pc0), .instr(instr0), .instr_31_30(a0), .instr_29_25(b0), .instr_27_24(c0),
    .instr_27_0(d0), .stall_cnt(sc0)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a FIFO of capacity 2 (skid) or 1 (no skid); pop before push each edge
  always @(posedge clk) begin
    bit acc1, acc0, pop1, pop0;
    acc1 = if_valid && (q1.size() < 2);
    acc0 = if_valid && ((q0.size() == 0) || id_ready);
    pop1 = id_ready && (q1.size() > 0);
    pop0 = id_ready && (q0.size() > 0);
    if (rst) begin
      q1.delete(); q0.delete();
      cnt1 = 0; cnt0 = 0;
    end else begin
      if (q1.size() > 0 && !id_ready && cnt1 < CNT_SAT) cnt1++;
      if (q0.size() > 0 && !id_ready && cnt0 < CNT_SAT) cnt0++;
      if (flush) begin
        q1.delete(); q0.delete();
      end else begin
        if (pop1) void'(q1.pop_front());
        if (acc1) q1.push_back('{pc: pc_out, instr: instruction});
        if (pop0) void'(q0.pop_front());
        if (acc0) q0.push_back('{pc: pc_out, instr: instruction});
      end
    end
  end

  task automatic check_dut(input string tag, input int qs, input if_id_entry_t hd,
                           input int cnt, input bit exp_rdy,
                           input logic v, input logic rdy, input logic [31:0] p,
                           input logic [31:0] i, input logic [1:0] a, input logic [4:0] b,
                           input logic [3:0] c, input logic [27:0] d, input logic [CW-1:0] sc);
    logic [31:0] ep, ei;
    ep = (qs > 0) ? hd.pc    : 32'h0;
    ei = (qs > 0) ? hd.instr : 32'h0;
    chk({tag, ".id_valid"},    v,   qs > 0);
    chk({tag, ".if_ready"},    rdy, exp_rdy);
    chk({tag, ".pc"},          p,   ep);
    chk({tag, ".instr"},       i,   ei);
    chk({tag, ".instr_31_30"}, a,   ei[31:30]);
    chk({tag, ".instr_29_25"}, b,   ei[29:25]);
    chk({tag, ".instr_27_24"}, c,   ei[27:24]);
    chk({tag, ".instr_27_0"},  d,   ei[27:0]);
    chk({tag, ".stall_cnt"},   sc,  cnt);
  endtask

  always @(negedge clk) begin
    if_id_entry_t h1, h0;
    if (chk_en) begin
      h1 = '0; h0 = '0;
      if (q1.size() > 0) h1 = q1[0];
      if (q0.size() > 0) h0 = q0[0];
      check_dut("skid",   q1.size(), h1, cnt1, q1.size() < 2,
                id_valid1, if_ready1, pc1, instr1, a1, b1, c1, d1, sc1);
      check_dut("noskid", q0.size(), h0, cnt0, (q0.size() == 0) || id_ready,
                id_valid0, if_ready0, pc0, instr0, a0, b0, c0, d0, sc0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; if_valid = 1'b0; id_ready = 1'b0;
    pc_out = '0; instruction = '0;
    step();
    chk_en = 1'b1;
    rst = 1'b0;
    chk("rst.if_ready", if_ready1, 1'b1);
    chk("rst.id_valid", id_valid1, 1'b0);
    chk("rst.instr", instr1, 32'h0);
    chk("rst.stall", sc1, 0);

    // Stream 1..4 with no backpressure
    id_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      pc_out = 32'(i); instruction = 32'hAFAFAFAF + 32'(i); if_valid = 1'b1;
      step();
      chk("stream.pc", pc1, 32'(i));
      chk("stream.op", a1, 2'b10);
      chk("stream.valid", id_valid1, 1'b1);
    end
    if_valid = 1'b0;
    step();
    chk("drain.valid", id_valid1, 1'b0);
    chk("drain.stall", sc1, 0);

    // Backpressure
    pc_out = 32'd10; instruction = 32'h1000_0010; if_valid = 1'b1;
    step();
    id_ready = 1'b0;
    pc_out = 32'd11; instruction = 32'h1000_0011;
    step();
    pc_out = 32'd12; instruction = 32'h1000_0012;
    step();
    step();
    chk("bp.stall", sc1, 3);
    chk("bp.pc_held", pc1, 32'd10);
    chk("bp.if_ready", if_ready1, 1'b0);
    id_ready = 1'b1;
    step();
    chk("bp.rel1", pc1, 32'd11);
    step();
    chk("bp.rel2", pc1, 32'd12);
    pc_out = 32'd13; instruction = 32'h1000_0013;
    step();
    chk("bp.rel3", pc1, 32'd13);
    if_valid = 1'b0;
    step();
    chk("bp.empty", id_valid1, 1'b0);
    chk("bp.stall_kept", sc1, 3);

    // Flush with both entries full
    id_ready = 1'b0; if_valid = 1'b1;
    pc_out = 32'd20; instruction = 32'h2000_0020;
    step();
    pc_out = 32'd21; instruction = 32'h2000_0021;
    step();
    flush = 1'b1; id_ready = 1'b1; pc_out = 32'd9; instruction = 32'h9999_9999;
    step();
    flush = 1'b0; if_valid = 1'b0;
    chk("flush.valid", id_valid1, 1'b0);
    chk("flush.instr", instr1, 32'h0);
    chk("flush.pc", pc1, 32'h0);
    chk("flush.stall", sc1, 4);
    step();
    chk("flush.no9", id_valid1, 1'b0);

    // Flush racing a real accept: the incoming entry is dropped
    id_ready = 1'b0; if_valid = 1'b1; pc_out = 32'd30; instruction = 32'h3000_0030;
    step();
    flush = 1'b1; pc_out = 32'd9; instruction = 32'h9999_9999;
    step();
    flush = 1'b0; if_valid = 1'b0;
    chk("flush2.valid", id_valid1, 1'b0);
    chk("flush2.stall", sc1, 5);

    // Reset mid-stall with S full
    if_valid = 1'b1; pc_out = 32'd40; instruction = 32'h4000_0040;
    step();
    pc_out = 32'd41; instruction = 32'h4000_0041;
    step();
    rst = 1'b1; flush = 1'b1;
    step();
    rst = 1'b0; flush = 1'b0; if_valid = 1'b0;
    chk("rst2.valid", id_valid1, 1'b0);
    chk("rst2.instr", instr1, 32'h0);
    chk("rst2.stall", sc1, 0);
    chk("rst2.if_ready", if_ready1, 1'b1);

    // Saturation over 20 stalled cycles
    if_valid = 1'b1; pc_out = 32'd50; instruction = 32'h5000_0050;
    step();
    if_valid = 1'b0;
    for (int i = 0; i < 20; i++) step();
    chk("sat.skid", sc1, 15);
    chk("sat.noskid", sc0, 15);

    // Non-skid ready follows id_ready combinationally
    chk("ns.ready_lo", if_ready0, 1'b0);
    id_ready = 1'b1;
    #1;
    chk("ns.ready_hi", if_ready0, 1'b1);
    if_valid = 1'b1;
    for (int i = 60; i <= 62; i++) begin
      pc_out = 32'(i); instruction = 32'h6000_0000 + 32'(i);
      step();
      chk("ns.pc", pc0, 32'(i));
      chk("ns.valid", id_valid0, 1'b1);
    end

    // Randomised traffic
    for (int n = 0; n < 2000; n++) begin
      if_valid    = ($urandom_range(0, 9) < 7);
      id_ready    = ($urandom_range(0, 9) < 6);
      flush       = ($urandom_range(0, 99) < 3);
      rst         = ($urandom_range(0, 99) < 1);
      pc_out      = $urandom;
      instruction = $urandom;
      step();
    end
    rst = 1'b0; flush = 1'b0; if_valid = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
